// File: rtl/gate_lamp_bank.sv
// Lamp row for a multi-input gate: wire-hit toggles flip a working lamp vector,
// and frame_end commits it atomically so the gate sees one vector per frame.
module gate_lamp_bank #(
    parameter int                    LAMP_COUNT = 2,
    parameter logic [LAMP_COUNT-1:0] INIT       = '0
) (
    input  logic                  clk,
    input  logic                  logic_reset,
    input  logic [LAMP_COUNT-1:0] toggle,
    input  logic                  frame_end,
    output logic [LAMP_COUNT-1:0] lamp_state,
    output logic [LAMP_COUNT-1:0] lamp_pending,
    output logic                  state_valid,
    output logic                  changed,
    output logic [7:0]            frame_hits
);

    localparam logic [0:0] ST_OPEN   = 1'b0;
    localparam logic [0:0] ST_COMMIT = 1'b1;

    logic [LAMP_COUNT-1:0] pending_p0;
    logic [LAMP_COUNT-1:0] committed_p1;
    logic [7:0]            hit_cnt_p0;
    logic [7:0]            frame_hits_p1;
    logic                  changed_p1;
    logic [0:0]            state_p1;

    logic [LAMP_COUNT-1:0] pending_next;
    logic [31:0]           hit_sum;

    function automatic logic [31:0] popcount(input logic [LAMP_COUNT-1:0] v);
        logic [31:0] cnt;
        cnt = '0;
        for (int i = 0; i < LAMP_COUNT; i++) begin
            cnt = cnt + {31'b0, v[i]};
        end
        return cnt;
    endfunction

    // Clamp at 255 so a long frame reports "many" instead of wrapping.
    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

    assign pending_next = pending_p0 ^ toggle;
    assign hit_sum      = {24'b0, hit_cnt_p0} + popcount(toggle);

    // Accumulate stage (pending, hit counter) -> commit stage (committed vector, stats)
    always_ff @(posedge clk or posedge logic_reset) begin
        if (logic_reset) begin
            pending_p0    <= INIT;
            committed_p1  <= INIT;
            hit_cnt_p0    <= 8'd0;
            frame_hits_p1 <= 8'd0;
            changed_p1    <= 1'b0;
            state_p1      <= ST_OPEN;
        end else begin
            pending_p0 <= pending_next;
            if (frame_end) begin
                // Toggles arriving with frame_end belong to the closing frame.
                committed_p1  <= pending_next;
                changed_p1    <= (pending_next != committed_p1);
                frame_hits_p1 <= sat8(hit_sum);
                hit_cnt_p0    <= 8'd0;
                state_p1      <= ST_COMMIT;
            end else begin
                hit_cnt_p0    <= sat8(hit_sum);
                state_p1      <= ST_OPEN;
            end
        end
    end

    assign lamp_state   = committed_p1;
    assign lamp_pending = pending_p0;
    assign state_valid  = (state_p1 == ST_COMMIT);
    assign changed      = changed_p1;
    assign frame_hits   = frame_hits_p1;

endmodule

// File: tb/tb_gate_lamp_bank.sv
// Scoreboard bench for gate_lamp_bank: stimulus queues expected commits,
// a negedge monitor pops one entry per state_valid pulse.
module tb_gate_lamp_bank;

    localparam int         LC   = 4;
    localparam logic [3:0] INIT = 4'b0101;

    logic          clk = 1'b0;
    logic          logic_reset = 1'b1;
    logic [LC-1:0] toggle = '0;
    logic          frame_end = 1'b0;
    logic [LC-1:0] lamp_state;
    logic [LC-1:0] lamp_pending;
    logic          state_valid;
    logic          changed;
    logic [7:0]    frame_hits;

    typedef struct {
        logic [LC-1:0] lamp;
        logic          chg;
        logic [7:0]    hits;
    } commit_t;

    commit_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    gate_lamp_bank #(.LAMP_COUNT(LC), .INIT(INIT)) dut (
        .clk          (clk),
        .logic_reset  (logic_reset),
        .toggle       (toggle),
        .frame_end    (frame_end),
        .lamp_state   (lamp_state),
        .lamp_pending (lamp_pending),
        .state_valid  (state_valid),
        .changed      (changed),
        .frame_hits   (frame_hits)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_commit(input logic [LC-1:0] lamp, input logic chg, input logic [7:0] hits);
        commit_t c;
        c.lamp = lamp;
        c.chg  = chg;
        c.hits = hits;
        sb.push_back(c);
    endtask

    task automatic drive(input logic [LC-1:0] tog, input logic fe);
        toggle    = tog;
        frame_end = fe;
        @(posedge clk);
        #1;
        toggle    = '0;
        frame_end = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!logic_reset && state_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_commit: state_valid high with no expected commit at %0t", $time);
            end else begin
                commit_t e;
                e = sb.pop_front();
                check("commit_lamp_state", 32'(lamp_state), 32'(e.lamp));
                check("commit_changed",    32'(changed),    32'(e.chg));
                check("commit_frame_hits", 32'(frame_hits), 32'(e.hits));
            end
        end
    end

    initial begin
        #12;
        logic_reset = 1'b0;
        #1;
        check("post_reset_lamp_state",   32'(lamp_state),   32'(INIT));
        check("post_reset_lamp_pending", 32'(lamp_pending), 32'(INIT));
        check("post_reset_state_valid",  32'(state_valid),  32'd0);
        check("post_reset_changed",      32'(changed),      32'd0);
        check("post_reset_frame_hits",   32'(frame_hits),   32'd0);

        // Move state away from INIT so the asynchronous reset is observable.
        drive(4'b1010, 1'b0);
        expect_commit(4'b1111, 1'b1, 8'd2);
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b0);
        #2;
        logic_reset = 1'b1;
        #1;
        check("async_reset_lamp_state",   32'(lamp_state),   32'(INIT));
        check("async_reset_lamp_pending", 32'(lamp_pending), 32'(INIT));
        check("async_reset_state_valid",  32'(state_valid),  32'd0);
        check("async_reset_changed",      32'(changed),      32'd0);
        check("async_reset_frame_hits",   32'(frame_hits),   32'd0);
        #1;
        logic_reset = 1'b0;

        // Single toggle then commit.
        drive(4'b0001, 1'b0);
        check("single_pending",        32'(lamp_pending), 32'h4);
        check("single_state_held",     32'(lamp_state),   32'h5);
        expect_commit(4'b0100, 1'b1, 8'd1);
        drive(4'b0000, 1'b1);

        // Parity cancel.
        drive(4'b0010, 1'b0);
        drive(4'b0000, 1'b0);
        drive(4'b0010, 1'b0);
        expect_commit(4'b0100, 1'b0, 8'd2);
        drive(4'b0000, 1'b1);

        // Toggle in the same cycle as frame_end, then check the counter restarted.
        expect_commit(4'b1100, 1'b1, 8'd1);
        drive(4'b1000, 1'b1);
        drive(4'b0001, 1'b0);
        expect_commit(4'b1101, 1'b1, 8'd1);
        drive(4'b0000, 1'b1);

        // Saturation (70 x 4 = 280 hits) then back-to-back frame_end.
        for (int i = 0; i < 70; i++) drive(4'b1111, 1'b0);
        check("sat_pending", 32'(lamp_pending), 32'hD);
        expect_commit(4'b1101, 1'b0, 8'd255);
        drive(4'b0000, 1'b1);
        expect_commit(4'b1101, 1'b0, 8'd0);
        drive(4'b0000, 1'b1);

        // Reset in the middle of a frame discards its toggles.
        drive(4'b0001, 1'b0);
        check("midframe_pending", 32'(lamp_pending), 32'hC);
        #2;
        logic_reset = 1'b1;
        #1;
        check("midframe_reset_pending", 32'(lamp_pending), 32'(INIT));
        #1;
        logic_reset = 1'b0;
        expect_commit(INIT, 1'b0, 8'd0);
        drive(4'b0000, 1'b1);

        for (int i = 0; i < 4; i++) drive(4'b0000, 1'b0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
